// File: rtl/uart_fifo.sv
// uart_fifo: memory-mapped RS-232 UART with RX/TX byte FIFOs, runtime baud
// divider, sticky error flags and a registered level interrupt.
// Optional build macro UART_PARITY_EN adds a parity bit (CTRL[2] selects odd).
module uart_fifo #(
  parameter int unsigned DIVIDER = 139,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] min,
  output logic [15:0] mout,
  input  logic [1:0]  bwe,
  input  logic        rs232_rx,
  output logic        rs232_tx,
  output logic        irq
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_e;

  logic [3:0] reg_sel;
  logic       unused_addr;
  logic       wr_data, wr_status, wr_div, wr_ctrl;
  assign reg_sel     = addr[3:0];
  assign unused_addr = ^addr[15:4];
  assign wr_data     = bwe[0] && (reg_sel == 4'h0);
  assign wr_status   = bwe[0] && (reg_sel == 4'h2);
  assign wr_div      = (bwe == 2'b11) && (reg_sel == 4'h6);
  assign wr_ctrl     = bwe[0] && (reg_sel == 4'h8);

  logic [15:0] div_q;
  logic [2:0]  ctrl_q;
  logic        ovr_q, ferr_q, perr_q;
  logic [15:0] mout_q, rd_d;
  logic        irq_q, irq_d;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q, tx_cnt, rx_cnt;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push, tx_pop, rx_push, rx_pop, ovr_set;
  logic [7:0]    tx_head, rx_head;

  state_e      tx_st_q, rx_st_q;
  logic [15:0] tx_tmr_q, rx_tmr_q;
  logic [2:0]  tx_bit_q, rx_bit_q;
  logic [7:0]  tx_sh_q, rx_sh_q, ev_byte_q;
  logic        tx_q, tx_idle;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        ev_push_q, ev_ferr_q, ev_perr_q;
`ifdef UART_PARITY_EN
  logic        tx_par_q, rx_pend_q;
`endif

  assign tx_cnt   = tx_wp_q - tx_rp_q;
  assign rx_cnt   = rx_wp_q - rx_rp_q;
  assign tx_empty = (tx_cnt == '0);
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = (tx_cnt == PW'(DEPTH));
  assign rx_full  = (rx_cnt == PW'(DEPTH));
  assign tx_head  = tx_mem[tx_rp_q[FIFO_AW-1:0]];
  assign rx_head  = rx_mem[rx_rp_q[FIFO_AW-1:0]];
  assign tx_idle  = tx_empty && (tx_st_q == S_IDLE);

  // Transmitter pops on leaving IDLE, or at the end of STOP for back-to-back frames
  assign tx_pop  = !tx_empty && ((tx_st_q == S_IDLE) || ((tx_st_q == S_STOP) && (tx_tmr_q == '0)));
  assign tx_push = wr_data && (!tx_full || tx_pop);
  assign rx_pop  = wr_status && min[0] && !rx_empty;
  assign rx_push = ev_push_q && (!rx_full || rx_pop);
  assign ovr_set = ev_push_q && rx_full && !rx_pop;

  // FIFO pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[FIFO_AW-1:0]] <= min[7:0];
    if (rx_push) rx_mem[rx_wp_q[FIFO_AW-1:0]] <= ev_byte_q;
  end

  // Control registers and sticky flags (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= 16'(DIVIDER);
      ctrl_q <= '0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (wr_div) div_q <= (min < 16'd16) ? 16'd16 : min;
`ifdef UART_PARITY_EN
      if (wr_ctrl) ctrl_q <= min[2:0];
`else
      if (wr_ctrl) ctrl_q <= {1'b0, min[1:0]};
`endif
      if (ovr_set) ovr_q <= 1'b1;
      else if (wr_status && min[1]) ovr_q <= 1'b0;
      if (ev_ferr_q) ferr_q <= 1'b1;
      else if (wr_status && min[2]) ferr_q <= 1'b0;
      if (ev_perr_q) perr_q <= 1'b1;
      else if (wr_status && min[3]) perr_q <= 1'b0;
    end
  end

  // Transmit FSM: one bit per DIV clocks, divider sampled at each bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q  <= S_IDLE;
      tx_tmr_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_st_q  <= S_START;
      tx_tmr_q <= div_q - 16'd1;
      tx_bit_q <= '0;
      tx_sh_q  <= tx_head;
      tx_q     <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q <= (^tx_head) ^ ctrl_q[2];
`endif
    end else if (tx_st_q != S_IDLE) begin
      if (tx_tmr_q != '0) begin
        tx_tmr_q <= tx_tmr_q - 16'd1;
      end else begin
        tx_tmr_q <= div_q - 16'd1;
        case (tx_st_q)
          S_START: begin
            tx_st_q <= S_DATA;
            tx_q    <= tx_sh_q[0];
          end
          S_DATA: begin
            if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_st_q <= S_PARITY;
              tx_q    <= tx_par_q;
`else
              tx_st_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              tx_q     <= tx_sh_q[1];
            end
          end
          S_PARITY: begin
            tx_st_q <= S_STOP;
            tx_q    <= 1'b1;
          end
          default: begin
            tx_st_q <= S_IDLE;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  // Receive FSM: synchronize, detect falling edge, sample mid-bit, emit one-cycle events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_tmr_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      ev_byte_q <= '0;
      ev_push_q <= 1'b0;
      ev_ferr_q <= 1'b0;
      ev_perr_q <= 1'b0;
`ifdef UART_PARITY_EN
      rx_pend_q <= 1'b0;
`endif
    end else begin
      rx_s1_q   <= rs232_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      ev_push_q <= 1'b0;
      ev_ferr_q <= 1'b0;
      ev_perr_q <= 1'b0;
      case (rx_st_q)
        S_IDLE: begin
          if (!rx_s2_q && rx_prev_q) begin
            rx_st_q  <= S_START;
            rx_tmr_q <= {1'b0, div_q[15:1]} - 16'd1;
          end
        end
        S_WAIT: begin
          if (rx_s2_q) rx_st_q <= S_IDLE;
        end
        default: begin
          if (rx_tmr_q != '0) begin
            rx_tmr_q <= rx_tmr_q - 16'd1;
          end else begin
            rx_tmr_q <= div_q - 16'd1;
            case (rx_st_q)
              S_START: begin
                if (rx_s2_q) begin
                  rx_st_q <= S_IDLE;
                end else begin
                  rx_st_q  <= S_DATA;
                  rx_bit_q <= '0;
`ifdef UART_PARITY_EN
                  rx_pend_q <= 1'b0;
`endif
                end
              end
              S_DATA: begin
                rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_q <= rx_bit_q + 3'd1;
`ifdef UART_PARITY_EN
                if (rx_bit_q == 3'd7) rx_st_q <= S_PARITY;
`else
                if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
`endif
              end
`ifdef UART_PARITY_EN
              S_PARITY: begin
                rx_pend_q <= (^rx_sh_q) ^ rx_s2_q ^ ctrl_q[2];
                rx_st_q   <= S_STOP;
              end
`endif
              default: begin
                if (rx_s2_q) begin
                  rx_st_q   <= S_IDLE;
                  ev_byte_q <= rx_sh_q;
`ifdef UART_PARITY_EN
                  if (rx_pend_q) ev_perr_q <= 1'b1;
                  else ev_push_q <= 1'b1;
`else
                  ev_push_q <= 1'b1;
`endif
                end else begin
                  ev_ferr_q <= 1'b1;
                  rx_st_q   <= S_WAIT;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  // Read mux and interrupt condition
  always_comb begin
    rd_d = 16'hffff;
    case (reg_sel)
      4'h0:    rd_d = {8'h00, rx_head};
      4'h2:    rd_d = {10'b0, perr_q, ferr_q, tx_idle, ovr_q, !tx_full, !rx_empty};
      4'h4:    rd_d = {8'(tx_cnt), 8'(rx_cnt)};
      4'h6:    rd_d = div_q;
      4'h8:    rd_d = {13'b0, ctrl_q};
      default: rd_d = 16'hffff;
    endcase
    irq_d = (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_empty) ||
            (ctrl_q[0] && (ovr_q || ferr_q || perr_q));
  end

  // Registered bus read data and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mout_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mout_q <= rd_d;
      irq_q  <= irq_d;
    end
  end

  assign mout     = mout_q;
  assign irq      = irq_q;
  assign rs232_tx = tx_q;
endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: queue-based reference model for both
// directions, serial frame decoder on rs232_tx, randomized payload bytes.
module tb_uart_fifo;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] min = '0;
  logic [1:0]  bwe = '0;
  logic        rs232_rx = 1'b1;
  logic [15:0] mout;
  logic        rs232_tx;
  logic        irq;

  uart_fifo #(.DIVIDER(139), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .min(min), .mout(mout), .bwe(bwe),
    .rs232_rx(rs232_rx), .rs232_tx(rs232_tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bitc     = 16;
  logic [7:0] tx_got[$];
  int         tx_start[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rxq[$];
  logic m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0, m_odd = 1'b0;

  always @(negedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    addr = {12'h000, a}; min = d; bwe = be;
    @(negedge clk);
    bwe = 2'b00;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = {12'h000, a}; bwe = 2'b00;
    @(posedge clk);
    #1 d = mout;
  endtask

  function automatic logic [15:0] status_exp();
    return {10'b0, m_perr, m_ferr, 1'b1, m_ovr, 1'b1, rxq.size() != 0};
  endfunction

  // Drive one serial frame at the current bit length
  task automatic send_rx(input logic [7:0] b, input logic stop, input logic bad_par);
    rs232_rx = 1'b0;
    repeat (bitc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = b[i];
      repeat (bitc) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rs232_rx = (^b) ^ m_odd ^ bad_par;
    repeat (bitc) @(negedge clk);
`endif
    rs232_rx = stop;
    repeat (bitc) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (6) @(negedge clk);
    if (stop) begin
      if (bad_par) m_perr = 1'b1;
      else if (rxq.size() < DEPTH) rxq.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  // Serial decoder on rs232_tx, samples each bit in its middle
  initial begin
    logic [7:0] b;
    int t0;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      if (rs232_tx !== 1'b0) continue;
      t0 = cyc;
      repeat (bitc / 2) @(negedge clk);
      chk("tx_start_bit", {31'b0, rs232_tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (bitc) @(negedge clk);
        b[i] = rs232_tx;
      end
`ifdef UART_PARITY_EN
      repeat (bitc) @(negedge clk);
      chk("tx_parity_bit", {31'b0, rs232_tx}, {31'b0, (^b) ^ m_odd});
`endif
      repeat (bitc) @(negedge clk);
      chk("tx_stop_bit", {31'b0, rs232_tx}, 32'd1);
      tx_got.push_back(b);
      tx_start.push_back(t0);
    end
  end

  initial begin
    logic [15:0] rd;
    logic [7:0]  r;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("reset_tx", {31'b0, rs232_tx}, 32'd1);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    bus_read(4'h2, rd); chk("reset_status", rd, 16'h000a);
    bus_read(4'h6, rd); chk("reset_div", rd, 16'h008b);
    bus_read(4'h4, rd); chk("reset_count", rd, 16'h0000);
    bus_read(4'h8, rd); chk("reset_ctrl", rd, 16'h0000);
    bus_read(4'ha, rd); chk("undecoded", rd, 16'hffff);

    // Divider clamp and write-enable qualification
    bus_write(4'h6, 16'd5, 2'b11);
    bus_read(4'h6, rd); chk("div_clamp", rd, 16'd16);
    bus_write(4'h6, 16'd40, 2'b01);
    bus_read(4'h6, rd); chk("div_partial_we", rd, 16'd16);
    bitc = 16;

    // Transmit: back-to-back frames
    r = 8'($urandom);
    exp_tx.push_back(8'h55); exp_tx.push_back(8'ha3); exp_tx.push_back(r);
    foreach (exp_tx[i]) bus_write(4'h0, {8'h00, exp_tx[i]}, 2'b01);
    for (int k = 0; k < 1500 && tx_got.size() < 3; k++) @(negedge clk);
    chk("tx_frame_count", tx_got.size(), 3);
    for (int i = 0; i < 3 && i < tx_got.size(); i++) chk("tx_byte", {24'b0, tx_got[i]}, {24'b0, exp_tx[i]});
    for (int i = 1; i < tx_start.size(); i++) chk("tx_frame_spacing", tx_start[i] - tx_start[i-1], NB * 16);
    repeat (20) @(negedge clk);
    bus_read(4'h2, rd); chk("tx_idle_status", rd, 16'h000a);

    // Receive: overrun with a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1, 1'b0);
    bus_read(4'h4, rd); chk("rx_count_full", rd, {8'h00, 8'(rxq.size())});
    bus_read(4'h2, rd); chk("rx_overrun_status", rd, status_exp());
    for (int i = 0; i < 4; i++) begin
      bus_read(4'h0, rd); chk("rx_data", rd, {8'h00, rxq[0]});
      bus_write(4'h2, 16'h0001, 2'b01);
      void'(rxq.pop_front());
    end
    bus_read(4'h2, rd); chk("rx_drained_status", rd, status_exp());
    bus_write(4'h2, 16'h0002, 2'b01); m_ovr = 1'b0;
    bus_read(4'h2, rd); chk("overrun_cleared", rd, status_exp());

    // Random payloads
    for (int i = 0; i < 3; i++) send_rx(8'($urandom), 1'b1, 1'b0);
    while (rxq.size() != 0) begin
      bus_read(4'h0, rd); chk("rx_rand_data", rd, {8'h00, rxq[0]});
      bus_write(4'h2, 16'h0001, 2'b01);
      void'(rxq.pop_front());
    end

    // Framing error
    send_rx(8'h3c, 1'b0, 1'b0);
    bus_read(4'h2, rd); chk("framing_status", rd, status_exp());
    bus_read(4'h4, rd); chk("framing_count", rd, 16'h0000);
    bus_write(4'h2, 16'h0004, 2'b01); m_ferr = 1'b0;
    bus_read(4'h2, rd); chk("framing_cleared", rd, status_exp());

    // Short low glitch is a false start
    bus_write(4'h6, 16'd32, 2'b11);
    bitc = 32;
    rs232_rx = 1'b0;
    repeat (8) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (100) @(negedge clk);
    bus_read(4'h2, rd); chk("glitch_status", rd, 16'h000a);
    bus_read(4'h4, rd); chk("glitch_count", rd, 16'h0000);
    send_rx(8'($urandom), 1'b1, 1'b0);
    bus_read(4'h0, rd); chk("rx_div32_data", rd, {8'h00, rxq[0]});

    // Interrupt sources
    bus_write(4'h8, 16'h0001, 2'b01);
    repeat (2) @(negedge clk);
    chk("irq_rx_nonempty", {31'b0, irq}, 32'd1);
    bus_write(4'h2, 16'h0001, 2'b01);
    void'(rxq.pop_front());
    repeat (2) @(negedge clk);
    chk("irq_rx_empty", {31'b0, irq}, 32'd0);
    bus_write(4'h8, 16'h0002, 2'b01);
    repeat (2) @(negedge clk);
    chk("irq_tx_empty", {31'b0, irq}, 32'd1);
    bus_write(4'h8, 16'h0007, 2'b01);
    bus_read(4'h8, rd);
`ifdef UART_PARITY_EN
    chk("ctrl_readback", rd, 16'h0007);
`else
    chk("ctrl_readback", rd, 16'h0003);
`endif
    bus_write(4'h8, 16'h0000, 2'b01);
    repeat (2) @(negedge clk);
    chk("irq_disabled", {31'b0, irq}, 32'd0);

`ifdef UART_PARITY_EN
    // Parity error discards the byte and raises irq
    bus_write(4'h8, 16'h0001, 2'b01); m_odd = 1'b0;
    send_rx(8'h07, 1'b1, 1'b1);
    chk("irq_parity", {31'b0, irq}, 32'd1);
    bus_read(4'h2, rd); chk("parity_status", rd, status_exp());
    bus_read(4'h4, rd); chk("parity_count", rd, 16'h0000);
    bus_write(4'h2, 16'h0008, 2'b01); m_perr = 1'b0;
    bus_read(4'h2, rd); chk("parity_cleared", rd, status_exp());
    bus_write(4'h8, 16'h0004, 2'b01); m_odd = 1'b1;
    send_rx(8'($urandom), 1'b1, 1'b0);
    bus_read(4'h0, rd); chk("odd_parity_data", rd, {8'h00, rxq[0]});
    bus_read(4'h2, rd); chk("odd_parity_status", rd, status_exp());
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
